// File: rtl/calc_pkg.sv
// calc_pkg: shared operator codes, FSM states and default operand width for the calculator.
package calc_pkg;
    localparam int CALC_WIDTH = 10;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_e;
endpackage

// File: rtl/calc_if.sv
// calc_if: operand/request and result/handshake bundle between the decoder side and calc_core.
interface calc_if import calc_pkg::*; #(parameter int WIDTH = CALC_WIDTH) ();
    logic start, sig1, busy, done, res_neg, err;
    logic [WIDTH-1:0] num1, num2, rem_mag;
    logic [1:0] oper;
    logic [2*WIDTH-1:0] res_mag;
    modport master(output start, num1, sig1, num2, oper, input busy, done, res_mag, res_neg, rem_mag, err);
    modport slave(input start, num1, sig1, num2, oper, output busy, done, res_mag, res_neg, rem_mag, err);
endinterface

// File: rtl/calc_iter_unit.sv
// calc_iter_unit: one-bit-per-step shift-add multiplier / restoring divider sharing one shift register.
module calc_iter_unit import calc_pkg::*; #(parameter int WIDTH = CALC_WIDTH) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               mode,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] prod_quo,
    output logic [WIDTH-1:0]   rem
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH:0] p_q, p_d, sh;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH:0] sum;
    // p holds {partial product, multiplier} for mul and {remainder, quotient} for div
    always_comb begin
        sum = p_q[2*WIDTH:WIDTH] + (p_q[0] ? {1'b0, d_q} : '0);
        sh = p_q << 1;
        p_d = p_q;
        d_d = d_q;
        cnt_d = cnt_q;
        if (load) begin
            p_d = {{(WIDTH+1){1'b0}}, a};
            d_d = b;
            cnt_d = CW'(WIDTH);
        end else if (step) begin
            cnt_d = cnt_q - 1'b1;
            p_d = !mode ? {1'b0, sum, p_q[WIDTH-1:1]}
                : sh[2*WIDTH:WIDTH] >= {1'b0, d_q} ? {sh[2*WIDTH:WIDTH] - {1'b0, d_q}, sh[WIDTH-1:1], 1'b1}
                : sh;
        end
    end
    always_ff @(posedge clk)
        if (rst) begin
            p_q <= '0;
            d_q <= '0;
            cnt_q <= '0;
        end else begin
            p_q <= p_d;
            d_q <= d_d;
            cnt_q <= cnt_d;
        end
    // results reflect the step being taken this cycle so the caller can commit on the last one
    assign last = cnt_q == CW'(1);
    assign prod_quo = mode ? {{WIDTH{1'b0}}, p_d[WIDTH-1:0]} : p_d[2*WIDTH-1:0];
    assign rem = mode ? p_d[2*WIDTH-1:WIDTH] : '0;
endmodule

// File: rtl/calc_core.sv
// calc_core: sign-magnitude add/sub/mul/div over a start/busy/done handshake.
module calc_core import calc_pkg::*; #(parameter int WIDTH = CALC_WIDTH) (
    input logic   clk,
    input logic   rst,
    calc_if.slave bus
);
    localparam int RW = 2 * WIDTH;
    state_e state_q, state_d;
    logic [WIDTH-1:0] n1_q, n1_d, n2_q, n2_d, rem_q, rem_d, it_rem;
    logic [1:0] op_q, op_d;
    logic s1_q, s1_d, busy_q, busy_d, done_q, done_d, neg_q, neg_d, err_q, err_d;
    logic [RW-1:0] mag_q, mag_d, it_res;
    logic load, step, it_last;
    logic signed [WIDTH+1:0] op_a, op_b, as_sum;
    logic [WIDTH+1:0] as_mag;
    calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk(clk), .rst(rst), .load(load), .mode(op_q == OP_DIV), .step(step),
        .a(n1_q), .b(n2_q), .last(it_last), .prod_quo(it_res), .rem(it_rem)
    );
    always_comb begin
        op_a = s1_q ? -$signed({2'b00, n1_q}) : $signed({2'b00, n1_q});
        op_b = $signed({2'b00, n2_q});
        as_sum = op_q == OP_SUB ? op_a - op_b : op_a + op_b;
        as_mag = as_sum[WIDTH+1] ? -as_sum : as_sum;
        state_d = state_q;
        {n1_d, s1_d, n2_d, op_d} = {n1_q, s1_q, n2_q, op_q};
        {mag_d, neg_d, rem_d, err_d} = {mag_q, neg_q, rem_q, err_q};
        done_d = 1'b0;
        load = 1'b0;
        step = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                {n1_d, s1_d, n2_d, op_d} = {bus.num1, bus.sig1, bus.num2, bus.oper};
                {rem_d, err_d} = '0;
                state_d = S_EXEC;
            end
            S_EXEC: if (op_q == OP_ADD || op_q == OP_SUB) begin
                mag_d = RW'(as_mag);
                neg_d = as_sum[WIDTH+1];
                done_d = 1'b1;
                state_d = S_DONE;
            end else if (op_q == OP_DIV && n2_q == '0) begin
                {mag_d, neg_d, rem_d} = '0;
                err_d = 1'b1;
                done_d = 1'b1;
                state_d = S_DONE;
            end else begin
                load = 1'b1;
                state_d = S_ITER;
            end
            S_ITER: begin
                step = 1'b1;
                if (it_last) begin
                    mag_d = it_res;
                    neg_d = s1_q & (it_res != '0);
                    rem_d = it_rem;
                    done_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= S_IDLE;
            {n1_q, s1_q, n2_q, op_q} <= '0;
            {mag_q, neg_q, rem_q, err_q, busy_q, done_q} <= '0;
        end else begin
            state_q <= state_d;
            {n1_q, s1_q, n2_q, op_q} <= {n1_d, s1_d, n2_d, op_d};
            {mag_q, neg_q, rem_q, err_q, busy_q, done_q} <= {mag_d, neg_d, rem_d, err_d, busy_d, done_d};
        end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.res_mag = mag_q;
    assign bus.res_neg = neg_q;
    assign bus.rem_mag = rem_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed vectors against an arithmetic reference model checked every cycle.
module tb_calc_core;
    logic clk = 0, rst = 1;
    int cyc = 0, total = 0, passed = 0, acc_k = 0;
    calc_if #(.WIDTH(10)) bus ();
    calc_core #(.WIDTH(10)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int acc; int dn; int mag; int rem; bit neg; bit err;} txn_t;
    txn_t cur;
    bit cur_v = 0;
    int h_mag = 0, h_rem = 0, e_mag, e_rem;
    bit h_neg = 0, h_err = 0, e_neg, e_err, e_busy, e_done;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic txn_t model(input int n1, input bit s, input int n2, input int op, input int k);
        txn_t t;
        int a, r;
        a = s ? -n1 : n1;
        t.acc = k; t.dn = k + 2; t.mag = 0; t.rem = 0; t.neg = 0; t.err = 0;
        if (op < 2) begin
            r = op == 0 ? a + n2 : a - n2;
            t.neg = r < 0;
            t.mag = r < 0 ? -r : r;
        end else if (op == 2) begin
            t.dn = k + 12; t.mag = n1 * n2; t.neg = s && t.mag != 0;
        end else if (n2 == 0) t.err = 1;
        else begin
            t.dn = k + 12; t.mag = n1 / n2; t.rem = n1 % n2; t.neg = s && t.mag != 0;
        end
        return t;
    endfunction

    // a request is taken only when no transaction is in flight up to and including its done cycle
    always @(posedge clk)
        if (rst) cur_v <= 0;
        else if (bus.start && !(cur_v && cyc <= cur.dn)) begin
            cur <= model(int'(bus.num1), bus.sig1, int'(bus.num2), int'(bus.oper), cyc);
            cur_v <= 1;
        end

    always_comb begin
        {e_mag, e_rem, e_neg, e_err} = {h_mag, h_rem, h_neg, h_err};
        if (cur_v && cyc == cur.acc + 1) {e_rem, e_err} = '0;
        if (cur_v && cyc == cur.dn) {e_mag, e_rem, e_neg, e_err} = {cur.mag, cur.rem, cur.neg, cur.err};
        e_busy = cur_v && cyc > cur.acc && cyc <= cur.dn;
        e_done = cur_v && cyc == cur.dn;
    end

    always @(negedge clk)
        if (rst) {h_mag, h_rem, h_neg, h_err} <= '0;
        else begin
            {h_mag, h_rem, h_neg, h_err} <= {e_mag, e_rem, e_neg, e_err};
            chk("busy", bus.busy, e_busy);
            chk("done", bus.done, e_done);
            chk("res_mag", bus.res_mag, e_mag);
            chk("res_neg", bus.res_neg, e_neg);
            chk("rem_mag", bus.rem_mag, e_rem);
            chk("err", bus.err, e_err);
        end

    task automatic go(input int n1, input bit s, input int n2, input int op);
        @(posedge clk); #1;
        bus.start = 1; bus.num1 = 10'(n1); bus.sig1 = s; bus.num2 = 10'(n2); bus.oper = 2'(op);
        acc_k = cyc;
        @(posedge clk); #1;
        bus.start = 0; bus.num1 = 10'($urandom); bus.sig1 = 1'($urandom);
        bus.num2 = 10'($urandom); bus.oper = 2'($urandom);
    endtask

    task automatic wait_done(input string nm, input int lat, input int mag, input bit neg, input int rem, input bit er);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done;
        end
        chk({nm, "_seen"}, int'(seen), 1);
        if (seen) begin
            chk({nm, "_lat"}, cyc - acc_k, lat);
            chk({nm, "_mag"}, bus.res_mag, mag);
            chk({nm, "_neg"}, bus.res_neg, neg);
            chk({nm, "_rem"}, bus.rem_mag, rem);
            chk({nm, "_err"}, bus.err, er);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bus.start = 0; bus.num1 = 0; bus.sig1 = 0; bus.num2 = 0; bus.oper = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mag", bus.res_mag, 0);
        go(5, 1, 12, 0);    wait_done("add", 2, 7, 0, 0, 0);
        go(999, 1, 999, 1); wait_done("sub", 2, 1998, 1, 0, 0);
        go(5, 0, 5, 1);     wait_done("sub0", 2, 0, 0, 0, 0);
        go(999, 1, 999, 2); wait_done("mul", 12, 998001, 1, 0, 0);
        go(7, 1, 0, 2);     wait_done("mul0", 12, 0, 0, 0, 0);
        go(100, 1, 7, 3);
        repeat (3) @(posedge clk);
        @(posedge clk); #1 bus.start = 1;
        @(posedge clk); #1 bus.start = 0;
        wait_done("div", 12, 14, 1, 2, 0);
        go(7, 0, 0, 3);     wait_done("dbz", 2, 0, 0, 0, 1);
        go(3, 0, 4, 0);
        @(negedge clk);
        chk("err_clr", bus.err, 0);
        wait_done("add2", 2, 7, 0, 0, 0);
        // start held high: accepted, ignored in DONE, accepted again on the next IDLE cycle
        @(posedge clk); #1;
        bus.start = 1; bus.num1 = 20; bus.sig1 = 0; bus.num2 = 30; bus.oper = 0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 3) bus.start = 0;
            @(negedge clk);
            n += int'(bus.done);
        end
        chk("b2b_cnt", n, 2);
        go(123, 0, 45, 2);
        repeat (4) @(posedge clk);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_mag", bus.res_mag, 0);
        n = 0;
        repeat (15) begin
            @(negedge clk);
            n += int'(bus.done);
        end
        chk("mid_rst_nodone", n, 0);
        go(123, 0, 45, 2);  wait_done("mul_after", 12, 5535, 0, 0, 0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
